// File: rtl/serial_addsub_digit_if.sv
// serial_addsub_digit_if: start/done handshake and operand/result bus for the digit-serial adder/subtractor
//   start, sub, ain, bin : requester -> datapath (request, op select, operands)
//   sum, cout, overflow  : datapath -> requester (held result)
//   busy, done           : datapath -> requester (status)
interface serial_addsub_digit_if #(parameter int WIDTH = 8);
  logic start;
  logic sub;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic overflow;
  logic busy;
  logic done;
  modport master(output start, sub, ain, bin, input sum, cout, overflow, busy, done);
  modport slave(input start, sub, ain, bin, output sum, cout, overflow, busy, done);
endinterface

// File: rtl/serial_addsub_digit.sv
// serial_addsub_digit: digit-serial A+B / A-B, DIGIT bits per clock, with carry-out and signed overflow
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   io      : slave side of serial_addsub_digit_if (start/sub/ain/bin in; sum/cout/overflow/busy/done out)
module serial_addsub_digit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clock,
  input logic reset_n,
  serial_addsub_digit_if.slave io
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG) + 1;
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, sum_r;
  logic carry, cout_r, ovf_r;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT:0] dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  always_comb begin
    state_n = state == IDLE  ? (io.start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == '0 ? DONE : SHIFT) :
              state == DONE  ? (io.start ? DONE : IDLE) : IDLE;
    dsum = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]} + (DIGIT+1)'(carry);
    cat = {dsum[DIGIT-1:0], sum_r};
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (io.start) begin
          a <= io.ain;
          b <= io.sub ? ~io.bin : io.bin;
          carry <= io.sub;
          sum_r <= '0;
          cnt <= CNT_W'(NDIG - 1);
        end
        SHIFT: begin
          a <= a >> DIGIT;
          b <= b >> DIGIT;
          carry <= dsum[DIGIT];
          sum_r <= cat[WIDTH+DIGIT-1:DIGIT];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            cout_r <= dsum[DIGIT];
            // carry into the MSB is recovered from the MSB sum bit and its two addend bits
            ovf_r <= a[DIGIT-1] ^ b[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
          end
        end
        DONE: ;
        default: begin
          sum_r <= '0;
          cout_r <= 1'b0;
          ovf_r <= 1'b0;
        end
      endcase
    end
  end
  assign io.sum = sum_r;
  assign io.cout = cout_r;
  assign io.overflow = ovf_r;
  assign io.busy = state == SHIFT;
  assign io.done = state == DONE;
endmodule

// File: tb/tb_serial_addsub_digit.sv
// tb_serial_addsub_digit: directed checks of three serial_addsub_digit configurations
module tb_serial_addsub_digit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic [15:0] o_sum;
  logic o_cout, o_ovf, o_busy, o_done;
  serial_addsub_digit_if #(.WIDTH(8)) i81();
  serial_addsub_digit_if #(.WIDTH(8)) i84();
  serial_addsub_digit_if #(.WIDTH(16)) i162();
  serial_addsub_digit #(.WIDTH(8), .DIGIT(1)) u81(.clock(clock), .reset_n(reset_n), .io(i81.slave));
  serial_addsub_digit #(.WIDTH(8), .DIGIT(4)) u84(.clock(clock), .reset_n(reset_n), .io(i84.slave));
  serial_addsub_digit #(.WIDTH(16), .DIGIT(2)) u162(.clock(clock), .reset_n(reset_n), .io(i162.slave));
  always #5 clock = ~clock;
  always_comb begin
    o_sum  = sel == 0 ? {8'h0, i81.sum} : sel == 1 ? {8'h0, i84.sum} : i162.sum;
    o_cout = sel == 0 ? i81.cout : sel == 1 ? i84.cout : i162.cout;
    o_ovf  = sel == 0 ? i81.overflow : sel == 1 ? i84.overflow : i162.overflow;
    o_busy = sel == 0 ? i81.busy : sel == 1 ? i84.busy : i162.busy;
    o_done = sel == 0 ? i81.done : sel == 1 ? i84.done : i162.done;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int s, input logic st, input logic sb, input logic [15:0] a, input logic [15:0] b);
    sel = s;
    i81.start = s == 0 && st;
    i84.start = s == 1 && st;
    i162.start = s == 2 && st;
    i81.sub = sb; i84.sub = sb; i162.sub = sb;
    i81.ain = a[7:0]; i84.ain = a[7:0]; i162.ain = a;
    i81.bin = b[7:0]; i84.bin = b[7:0]; i162.bin = b;
  endtask
  task automatic op(input int s, input logic sb, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] es, input logic ec, input logic eo, input int nd, input bit hold);
    int n = 0;
    int bc = 0;
    drive(s, 1'b1, sb, a, b);
    @(negedge clock);
    if (!hold) drive(s, 1'b0, ~sb, ~a, ~b);
    while (!o_done && n < 40) begin
      if (o_busy) bc++;
      @(negedge clock);
      n++;
    end
    chk("latency", n, nd);
    chk("busy_cycles", bc, nd);
    chk("sum", o_sum, es);
    chk("cout", o_cout, ec);
    chk("overflow", o_ovf, eo);
    chk("busy_in_done", o_busy, 0);
    if (!hold) begin
      @(negedge clock);
      chk("idle_done", o_done, 0);
      chk("idle_sum_held", o_sum, es);
    end
  endtask
  initial begin
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_sum", o_sum, 0);
      chk("rst_flags", {o_cout, o_ovf, o_busy, o_done}, 0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    op(0, 1'b0, 16'h5A, 16'h3C, 16'h96, 1'b0, 1'b1, 8, 1'b0);
    op(0, 1'b1, 16'h10, 16'h20, 16'hF0, 1'b0, 1'b0, 8, 1'b0);
    op(1, 1'b0, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0, 2, 1'b0);
    op(1, 1'b1, 16'h80, 16'h01, 16'h7F, 1'b1, 1'b1, 2, 1'b0);
    op(2, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 8, 1'b0);
    op(2, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 8, 1'b0);
    op(0, 1'b0, 16'h5A, 16'h3C, 16'h96, 1'b0, 1'b1, 8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_done", o_done, 1);
      chk("hold_sum", o_sum, 16'h96);
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    chk("drop_done", o_done, 0);
    chk("drop_busy", o_busy, 0);
    op(0, 1'b1, 16'h03, 16'h05, 16'hFE, 1'b0, 1'b0, 8, 1'b0);
    drive(0, 1'b1, 1'b0, 16'h11, 16'h22);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clock);
    @(negedge clock);
    chk("mid_busy", o_busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("mid_rst_sum", o_sum, 0);
    chk("mid_rst_flags", {o_cout, o_ovf, o_busy, o_done}, 0);
    @(negedge clock);
    chk("post_rst_idle", {o_busy, o_done}, 0);
    op(0, 1'b0, 16'h11, 16'h22, 16'h33, 1'b0, 1'b0, 8, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
